regfile_sb: RTL and testbench

Parametrised multi-port register file with same-cycle write-through bypass, hardwired zero register, full asynchronous clear, and a per-register busy scoreboard. It sits between decode/issue and writeback in the pipelined core. Issue reserves a destination register. Writeback stores the result and releases the reservation. Read ports return operand data plus a busy flag, so the hazard unit can stall without tracking destinations itself.

---
 rtl/regfile_sb.sv | 101 ++++++++++
 tb/tb_regfile_sb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write-through bypass, optional hardwired
// zero register, asynchronous clear and a per-register busy scoreboard.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rstd,
   input  logic [NRD*ADDR_W-1:0] r_addr,
   output logic [NRD*DATA_W-1:0] r_data,
   output logic [NRD-1:0]        r_busy,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_W-1:0]     w_addr0,
   input  logic [ADDR_W-1:0]     w_addr1,
   input  logic [DATA_W-1:0]     w_data0,
   input  logic [DATA_W-1:0]     w_data1,
   input  logic                  rsv_en,
   input  logic [ADDR_W-1:0]     rsv_addr,
   output logic [ADDR_W:0]       pend_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [DEPTH-1:0]  busy_reg;
   logic [DEPTH-1:0]  busy_next;
   logic [ADDR_W:0]   pend_cnt_reg;
   logic [ADDR_W:0]   pend_cnt_next;
   logic              wr0_ok;
   logic              wr1_ok;

   // Writes aimed at a hardwired zero register are dropped before reaching storage.
   assign wr0_ok = we0 && !(ZERO_REG != 0 && w_addr0 == '0);
   assign wr1_ok = we1 && !(ZERO_REG != 0 && w_addr1 == '0);

   // Reserve beats release, so a register re-issued in its writeback cycle stays busy.
   always_comb begin
      busy_next     = busy_reg;
      pend_cnt_next = '0;
      for (int j = 0; j < DEPTH; j++) begin
         if ((we0 && w_addr0 == ADDR_W'(j)) || (we1 && w_addr1 == ADDR_W'(j)))
            busy_next[j] = 1'b0;
         if (rsv_en && rsv_addr == ADDR_W'(j))
            busy_next[j] = 1'b1;
         if (ZERO_REG != 0 && j == 0)
            busy_next[j] = 1'b0;
         pend_cnt_next = pend_cnt_next + (ADDR_W + 1)'(busy_next[j]);
      end
   end

   always_ff @(posedge clk or negedge rstd) begin
      if (!rstd) begin
         for (int j = 0; j < DEPTH; j++)
            mem_reg[j] <= '0;
         busy_reg     <= '0;
         pend_cnt_reg <= '0;
      end else begin
         if (wr0_ok)
            mem_reg[w_addr0] <= w_data0;
         if (wr1_ok)
            mem_reg[w_addr1] <= w_data1;
         busy_reg     <= busy_next;
         pend_cnt_reg <= pend_cnt_next;
      end
   end

   assign pend_cnt = pend_cnt_reg;

   generate
      for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] data;
         logic              busy;

         assign addr = r_addr[gi*ADDR_W +: ADDR_W];

         always_comb begin
            data = mem_reg[addr];
            busy = busy_next[addr];
            if (!rstd) begin
               data = '0;
               busy = 1'b0;
            end else if (ZERO_REG != 0 && addr == '0) begin
               data = '0;
               busy = 1'b0;
            end else if (we1 && w_addr1 == addr) begin
               data = w_data1;
            end else if (we0 && w_addr0 == addr) begin
               data = w_data0;
            end
         end

         assign r_data[gi*DATA_W +: DATA_W] = data;
         assign r_busy[gi]                  = busy;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed checks of regfile_sb: a default 2-port instance and a 4-port, 16-bit,
// 8-entry instance.
module tb_regfile_sb;

   logic        clk;
   logic        rstd;

   logic [9:0]  r_addr;
   logic [63:0] r_data;
   logic [1:0]  r_busy;
   logic        we0, we1, rsv_en;
   logic [4:0]  w_addr0, w_addr1, rsv_addr;
   logic [31:0] w_data0, w_data1;
   logic [5:0]  pend_cnt;

   logic [11:0] p_r_addr;
   logic [63:0] p_r_data;
   logic [3:0]  p_r_busy;
   logic        p_we0, p_we1, p_rsv_en;
   logic [2:0]  p_w_addr0, p_w_addr1, p_rsv_addr;
   logic [15:0] p_w_data0, p_w_data1;
   logic [3:0]  p_pend_cnt;

   int checks = 0;
   int errors = 0;

   regfile_sb u_dut (
      .clk(clk), .rstd(rstd), .r_addr(r_addr), .r_data(r_data), .r_busy(r_busy),
      .we0(we0), .we1(we1), .w_addr0(w_addr0), .w_addr1(w_addr1),
      .w_data0(w_data0), .w_data1(w_data1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .pend_cnt(pend_cnt)
   );

   regfile_sb #(.DATA_W(16), .ADDR_W(3), .NRD(4), .ZERO_REG(1)) u_dut4 (
      .clk(clk), .rstd(rstd), .r_addr(p_r_addr), .r_data(p_r_data), .r_busy(p_r_busy),
      .we0(p_we0), .we1(p_we1), .w_addr0(p_w_addr0), .w_addr1(p_w_addr1),
      .w_data0(p_w_data0), .w_data1(p_w_data1), .rsv_en(p_rsv_en), .rsv_addr(p_rsv_addr),
      .pend_cnt(p_pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      we0 = 0; we1 = 0; rsv_en = 0;
      w_addr0 = 0; w_addr1 = 0; rsv_addr = 0; w_data0 = 0; w_data1 = 0;
      p_we0 = 0; p_we1 = 0; p_rsv_en = 0;
      p_w_addr0 = 0; p_w_addr1 = 0; p_rsv_addr = 0; p_w_data0 = 0; p_w_data1 = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstd = 0; idle(); r_addr = 0; p_r_addr = 0;
      #2;
      checks++;
      if (pend_cnt !== 6'd0 || r_busy !== 2'b00) begin
         errors++; $display("FAIL reset_init pend=%0d busy=%b exp 0/00", pend_cnt, r_busy);
      end
      step(); rstd = 1;
      // write r5 and reserve r6, then clear everything
      we0 = 1; w_addr0 = 5; w_data0 = 32'hDEADBEEF; rsv_en = 1; rsv_addr = 6;
      step(); idle(); r_addr[4:0] = 5;
      #1;
      checks++;
      if (r_data[31:0] !== 32'hDEADBEEF || pend_cnt !== 6'd1) begin
         errors++; $display("FAIL reset_pre data=%h pend=%0d exp deadbeef/1", r_data[31:0], pend_cnt);
      end
      step();
      rstd = 0; we0 = 1; w_addr0 = 5; w_data0 = 32'h1234; rsv_en = 1; rsv_addr = 5;
      #1;
      checks++;
      if (r_data[31:0] !== 32'h0 || r_busy[0] !== 1'b0 || pend_cnt !== 6'd0) begin
         errors++; $display("FAIL reset_low data=%h busy=%b pend=%0d exp 0/0/0", r_data[31:0], r_busy[0], pend_cnt);
      end
      step(); idle(); rstd = 1;
      #1;
      checks++;
      if (r_data[31:0] !== 32'h0 || r_busy[0] !== 1'b0 || pend_cnt !== 6'd0) begin
         errors++; $display("FAIL reset_after data=%h busy=%b pend=%0d exp 0/0/0", r_data[31:0], r_busy[0], pend_cnt);
      end
      $display("test_reset done");
   endtask

   task automatic test_bypass();
      step();
      we0 = 1; we1 = 1; w_addr0 = 7; w_addr1 = 7; w_data0 = 32'h11; w_data1 = 32'h22;
      r_addr[9:5] = 7;
      #1;
      checks++;
      if (r_data[63:32] !== 32'h22) begin
         errors++; $display("FAIL bypass_same data=%h exp 00000022", r_data[63:32]);
      end
      step(); idle();
      #1;
      checks++;
      if (r_data[63:32] !== 32'h22) begin
         errors++; $display("FAIL bypass_stored data=%h exp 00000022", r_data[63:32]);
      end
      we0 = 1; w_addr0 = 8; w_data0 = 32'h33; r_addr[4:0] = 8;
      #1;
      checks++;
      if (r_data[31:0] !== 32'h33) begin
         errors++; $display("FAIL bypass_port0 data=%h exp 00000033", r_data[31:0]);
      end
      step(); idle();
      #1;
      checks++;
      if (r_data[31:0] !== 32'h33 || r_data[63:32] !== 32'h22) begin
         errors++; $display("FAIL bypass_both data=%h exp 00000022_00000033", r_data);
      end
      $display("test_bypass done");
   endtask

   task automatic test_zero();
      we0 = 1; we1 = 1; w_addr0 = 0; w_addr1 = 0; w_data0 = 32'hFFFFFFFF; w_data1 = 32'hFFFFFFFF;
      rsv_en = 1; rsv_addr = 0; r_addr[4:0] = 0;
      #1;
      checks++;
      if (r_data[31:0] !== 32'h0 || r_busy[0] !== 1'b0) begin
         errors++; $display("FAIL zero_same data=%h busy=%b exp 0/0", r_data[31:0], r_busy[0]);
      end
      step(); idle();
      #1;
      checks++;
      if (r_data[31:0] !== 32'h0 || r_busy[0] !== 1'b0 || pend_cnt !== 6'd0) begin
         errors++; $display("FAIL zero_after data=%h busy=%b pend=%0d exp 0/0/0", r_data[31:0], r_busy[0], pend_cnt);
      end
      $display("test_zero done");
   endtask

   task automatic test_scoreboard();
      rsv_en = 1; rsv_addr = 3; r_addr[4:0] = 3;
      #1;
      checks++;
      if (r_busy[0] !== 1'b1) begin
         errors++; $display("FAIL sb_rsv_same busy=%b exp 1", r_busy[0]);
      end
      step();
      checks++;
      if (pend_cnt !== 6'd1) begin
         errors++; $display("FAIL sb_pend1 pend=%0d exp 1", pend_cnt);
      end
      rsv_addr = 4;
      step(); idle(); r_addr[4:0] = 3; r_addr[9:5] = 4;
      #1;
      checks++;
      if (pend_cnt !== 6'd2 || r_busy !== 2'b11) begin
         errors++; $display("FAIL sb_pend2 pend=%0d busy=%b exp 2/11", pend_cnt, r_busy);
      end
      we1 = 1; w_addr1 = 3; w_data1 = 32'hABCD;
      #1;
      checks++;
      if (r_busy !== 2'b10 || r_data[31:0] !== 32'hABCD) begin
         errors++; $display("FAIL sb_release busy=%b data=%h exp 10/0000abcd", r_busy, r_data[31:0]);
      end
      step(); idle();
      #1;
      checks++;
      if (pend_cnt !== 6'd1 || r_busy !== 2'b10) begin
         errors++; $display("FAIL sb_after pend=%0d busy=%b exp 1/10", pend_cnt, r_busy);
      end
      rsv_en = 1; rsv_addr = 4;
      step(); idle();
      #1;
      checks++;
      if (pend_cnt !== 6'd1 || r_busy[1] !== 1'b1) begin
         errors++; $display("FAIL sb_rersv pend=%0d busy=%b exp 1/1", pend_cnt, r_busy[1]);
      end
      $display("test_scoreboard done");
   endtask

   task automatic test_collision();
      rsv_en = 1; rsv_addr = 9;
      step(); idle(); r_addr[4:0] = 9;
      #1;
      checks++;
      if (pend_cnt !== 6'd2 || r_busy[0] !== 1'b1) begin
         errors++; $display("FAIL col_setup pend=%0d busy=%b exp 2/1", pend_cnt, r_busy[0]);
      end
      we0 = 1; w_addr0 = 9; w_data0 = 32'h55; rsv_en = 1; rsv_addr = 9;
      #1;
      checks++;
      if (r_busy[0] !== 1'b1 || r_data[31:0] !== 32'h55) begin
         errors++; $display("FAIL col_same busy=%b data=%h exp 1/00000055", r_busy[0], r_data[31:0]);
      end
      step(); idle();
      #1;
      checks++;
      if (r_data[31:0] !== 32'h55 || r_busy[0] !== 1'b1 || pend_cnt !== 6'd2) begin
         errors++; $display("FAIL col_after data=%h busy=%b pend=%0d exp 00000055/1/2", r_data[31:0], r_busy[0], pend_cnt);
      end
      $display("test_collision done");
   endtask

   task automatic test_param();
      logic [15:0] exp_v [4];
      exp_v[0] = 16'h1111; exp_v[1] = 16'h2222; exp_v[2] = 16'h3333; exp_v[3] = 16'h4444;
      p_we0 = 1; p_we1 = 1; p_w_addr0 = 1; p_w_data0 = 16'h1111; p_w_addr1 = 2; p_w_data1 = 16'h2222;
      step();
      p_w_addr0 = 3; p_w_data0 = 16'h3333; p_w_addr1 = 4; p_w_data1 = 16'h4444;
      step(); idle();
      for (int i = 0; i < 4; i++) p_r_addr[i*3 +: 3] = 3'(i + 1);
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (p_r_data[i*16 +: 16] !== exp_v[i]) begin
            errors++; $display("FAIL param_fwd port%0d data=%h exp %h", i, p_r_data[i*16 +: 16], exp_v[i]);
         end
      end
      for (int i = 0; i < 4; i++) p_r_addr[i*3 +: 3] = 3'(4 - i);
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (p_r_data[i*16 +: 16] !== exp_v[3 - i]) begin
            errors++; $display("FAIL param_rev port%0d data=%h exp %h", i, p_r_data[i*16 +: 16], exp_v[3 - i]);
         end
      end
      for (int a = 0; a < 8; a++) begin
         p_rsv_en = 1; p_rsv_addr = 3'(a);
         step();
      end
      idle();
      p_r_addr = {3'd7, 3'd5, 3'd1, 3'd0};
      #1;
      checks++;
      if (p_pend_cnt !== 4'd7 || p_r_busy !== 4'b1110) begin
         errors++; $display("FAIL param_all pend=%0d busy=%b exp 7/1110", p_pend_cnt, p_r_busy);
      end
      $display("test_param done");
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_zero();
      test_scoreboard();
      test_collision();
      test_param();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
